// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array host streamer: FSM states,
// default array geometry and lane pack/unpack helpers.
package sa_pkg;

  localparam int DEF_ROWS     = 8;
  localparam int DEF_INWIDTH  = 8;
  localparam int DEF_OUTWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } stream_state_t;

  typedef logic [DEF_INWIDTH-1:0]  in_lanes_t  [DEF_ROWS];
  typedef logic [DEF_OUTWIDTH-1:0] out_lanes_t [DEF_ROWS];

  // Split a flat operand word into lanes; lane i sits at [i*INWIDTH +: INWIDTH].
  function automatic in_lanes_t unpack_in(input logic [DEF_ROWS*DEF_INWIDTH-1:0] flat);
    in_lanes_t lanes;
    for (int unsigned i = 0; i < DEF_ROWS; i++) begin
      lanes[i] = flat[i*DEF_INWIDTH +: DEF_INWIDTH];
    end
    return lanes;
  endfunction

  // Flatten per-column results; column i lands at [i*OUTWIDTH +: OUTWIDTH].
  function automatic logic [DEF_ROWS*DEF_OUTWIDTH-1:0] pack_out(input out_lanes_t lanes);
    logic [DEF_ROWS*DEF_OUTWIDTH-1:0] flat;
    flat = '0;
    for (int unsigned i = 0; i < DEF_ROWS; i++) begin
      flat[i*DEF_OUTWIDTH +: DEF_OUTWIDTH] = lanes[i];
    end
    return flat;
  endfunction

endpackage

// File: rtl/sa_result_packer.sv
// Flattens the core's per-column result port into one memory word and
// detects a complete (all columns valid) result vector.
module sa_result_packer
  import sa_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int OUTWIDTH = DEF_OUTWIDTH
) (
  input  logic [OUTWIDTH-1:0]      routport [0:ROWS-1],
  input  logic [0:ROWS-1]          rvalidport,
  output logic [ROWS*OUTWIDTH-1:0] res_flat,
  output logic                     all_valid
);

  // Pack columns and reduce valids; a partially valid vector is never ready.
  always_comb begin
    res_flat = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      res_flat[i*OUTWIDTH +: OUTWIDTH] = routport[i];
    end
    all_valid = &rvalidport;
  end

endmodule

// File: rtl/sa_tile_streamer.sv
// Host-side tile streamer: reads K operand vectors from the A/W memories and
// feeds them to the systolic core, then drains ROWS result vectors into the
// result memory, reporting done or err.
module sa_tile_streamer
  import sa_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int INWIDTH  = DEF_INWIDTH,
  parameter int OUTWIDTH = DEF_OUTWIDTH,
  parameter int MAX_K    = 16,
  parameter int AW       = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(MAX_K):0]    cmd_k,
  input  logic [AW-1:0]             cmd_abase,
  input  logic [AW-1:0]             cmd_wbase,
  input  logic [AW-1:0]             cmd_rbase,
  output logic                      done,
  output logic                      err,
  output logic [AW-1:0]             a_raddr,
  input  logic [ROWS*INWIDTH-1:0]   a_rdata,
  output logic [AW-1:0]             w_raddr,
  input  logic [ROWS*INWIDTH-1:0]   w_rdata,
  output logic                      r_we,
  output logic [AW-1:0]             r_waddr,
  output logic [ROWS*OUTWIDTH-1:0]  r_wdata,
  output logic                      inpvalid,
  output logic [INWIDTH-1:0]        ainport [0:ROWS-1],
  output logic [INWIDTH-1:0]        winport [0:ROWS-1],
  input  logic [OUTWIDTH-1:0]       routport [0:ROWS-1],
  input  logic [0:ROWS-1]           rvalidport,
  output logic                      outread
);

  localparam int KW = $clog2(MAX_K) + 1;
  localparam int MW = $clog2(ROWS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  stream_state_t state, state_nxt;

  logic [KW-1:0]            k_q, n_cnt;
  logic [AW-1:0]            abase_q, wbase_q, rbase_q;
  logic [MW-1:0]            m_cnt;
  logic [TW-1:0]            wd_cnt;
  logic                     hold_q;
  logic                     rd_v1;
  logic                     k_legal, last_feed, last_vec, wd_expire;
  logic                     accept, done_nxt, err_nxt;
  logic                     all_valid;
  logic [ROWS*OUTWIDTH-1:0] res_flat;

  sa_result_packer #(
    .ROWS     (ROWS),
    .OUTWIDTH (OUTWIDTH)
  ) u_packer (
    .routport   (routport),
    .rvalidport (rvalidport),
    .res_flat   (res_flat),
    .all_valid  (all_valid)
  );

  assign k_legal   = (cmd_k != '0) && (cmd_k <= KW'(MAX_K));
  assign last_feed = (n_cnt == k_q - KW'(1));
  assign last_vec  = (m_cnt == MW'(ROWS - 1));
  assign wd_expire = (wd_cnt == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the combinational memory/core handshake outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    a_raddr   = '0;
    w_raddr   = '0;
    r_we      = 1'b0;
    r_waddr   = '0;
    r_wdata   = '0;
    outread   = 1'b0;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (k_legal) state_nxt = FEED;
          else         err_nxt   = 1'b1;
        end
      end
      FEED: begin
        a_raddr = abase_q + AW'(n_cnt);
        w_raddr = wbase_q + AW'(n_cnt);
        if (last_feed) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DRAIN;
      DRAIN: begin
        // hold_q blocks the cycle right after an accept so the core can retire the vector
        if (all_valid && !hold_q) begin
          accept  = 1'b1;
          r_we    = 1'b1;
          r_waddr = rbase_q + AW'(m_cnt);
          r_wdata = res_flat;
          outread = 1'b1;
          if (last_vec) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (wd_expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, feed/drain counters, read pipeline and status pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_q      <= '0;
      abase_q  <= '0;
      wbase_q  <= '0;
      rbase_q  <= '0;
      n_cnt    <= '0;
      m_cnt    <= '0;
      wd_cnt   <= '0;
      hold_q   <= 1'b0;
      rd_v1    <= 1'b0;
      inpvalid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < ROWS; i++) begin
        ainport[i] <= '0;
        winport[i] <= '0;
      end
    end else begin
      if (state == IDLE && cmd_valid && k_legal) begin
        k_q     <= cmd_k;
        abase_q <= cmd_abase;
        wbase_q <= cmd_wbase;
        rbase_q <= cmd_rbase;
      end
      n_cnt <= (state == FEED) ? n_cnt + KW'(1) : '0;
      // Address cycle -> memory data cycle -> registered onto the core port.
      rd_v1    <= (state == FEED);
      inpvalid <= rd_v1;
      if (rd_v1) begin
        for (int unsigned i = 0; i < ROWS; i++) begin
          ainport[i] <= a_rdata[i*INWIDTH +: INWIDTH];
          winport[i] <= w_rdata[i*INWIDTH +: INWIDTH];
        end
      end
      if (state != DRAIN) m_cnt <= '0;
      else if (accept)    m_cnt <= m_cnt + MW'(1);
      hold_q <= accept;
      if (state != DRAIN || accept) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + TW'(1);
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sa_tile_streamer.sv
// Self-checking bench for sa_tile_streamer: table of tile commands plus
// hand-written timeout and reset-abort sequences, with feed and result
// scoreboards filled at stimulus time.
module tb_sa_tile_streamer;

  localparam int ROWS  = 8;
  localparam int IW    = 8;
  localparam int OW    = 32;
  localparam int MAX_K = 16;
  localparam int AW    = 8;
  localparam int TO    = 1024;
  localparam int KW    = $clog2(MAX_K) + 1;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [KW-1:0]        cmd_k = '0;
  logic [AW-1:0]        cmd_abase = '0, cmd_wbase = '0, cmd_rbase = '0;
  logic                 done, err;
  logic [AW-1:0]        a_raddr, w_raddr;
  logic [ROWS*IW-1:0]   a_rdata, w_rdata;
  logic                 r_we;
  logic [AW-1:0]        r_waddr;
  logic [ROWS*OW-1:0]   r_wdata;
  logic                 inpvalid;
  logic [IW-1:0]        ainport [0:ROWS-1];
  logic [IW-1:0]        winport [0:ROWS-1];
  logic [OW-1:0]        routport [0:ROWS-1];
  logic [0:ROWS-1]      rvalidport = '0;
  logic                 outread;

  sa_tile_streamer #(
    .ROWS(ROWS), .INWIDTH(IW), .OUTWIDTH(OW), .MAX_K(MAX_K), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_abase(cmd_abase), .cmd_wbase(cmd_wbase), .cmd_rbase(cmd_rbase),
    .done(done), .err(err), .a_raddr(a_raddr), .a_rdata(a_rdata),
    .w_raddr(w_raddr), .w_rdata(w_rdata), .r_we(r_we), .r_waddr(r_waddr),
    .r_wdata(r_wdata), .inpvalid(inpvalid), .ainport(ainport), .winport(winport),
    .routport(routport), .rvalidport(rvalidport), .outread(outread)
  );

  always #5 clk = ~clk;

  // Operand memories with one-cycle read latency.
  logic [ROWS*IW-1:0] amem [0:255];
  logic [ROWS*IW-1:0] wmem [0:255];
  always @(posedge clk) begin
    a_rdata <= amem[a_raddr];
    w_rdata <= wmem[w_raddr];
  end

  typedef struct {
    logic [AW-1:0]      aa;
    logic [AW-1:0]      wa;
    logic [ROWS*IW-1:0] av;
    logic [ROWS*IW-1:0] wv;
  } feed_exp_t;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [ROWS*OW-1:0] data;
  } res_exp_t;

  typedef struct {
    logic [KW-1:0] k;
    logic [AW-1:0] ab;
    logic [AW-1:0] wb;
    logic [AW-1:0] rb;
    bit            bad;
  } vec_t;

  feed_exp_t feed_q[$];
  res_exp_t  res_q[$];

  int tests = 0;
  int fails = 0;

  int beats, first_beat, last_beat, n_we, n_or, n_done, n_err, samp, cur_k;
  logic prev_or;
  logic [AW-1:0] ah1, ah2, wh1, wh2;
  bit core_consumed;
  int core_left, core_idx;
  logic [AW-1:0] core_rb;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_mon();
    beats = 0; first_beat = 0; last_beat = 0; n_we = 0; n_or = 0;
    n_done = 0; n_err = 0; samp = 0; prev_or = 1'b0;
    core_consumed = 0; core_left = 0; core_idx = 0;
    feed_q.delete();
    res_q.delete();
  endtask

  // One clock: core model reacts after the edge, then all outputs are sampled.
  task automatic step();
    logic [ROWS*IW-1:0] ap, wp;
    logic [ROWS*OW-1:0] rp;
    res_exp_t  r;
    feed_exp_t f;
    @(posedge clk);
    #1;
    if (core_consumed) begin
      rvalidport    = '0;
      core_consumed = 0;
    end else if (core_left > 0 && rvalidport == '0) begin
      for (int i = 0; i < ROWS; i++) begin
        routport[i]     = $urandom;
        rp[i*OW +: OW]  = routport[i];
      end
      r.addr = core_rb + AW'(core_idx);
      r.data = rp;
      res_q.push_back(r);
      core_idx++;
      core_left--;
      rvalidport = '1;
    end
    #1;
    samp++;
    for (int i = 0; i < ROWS; i++) begin
      ap[i*IW +: IW] = ainport[i];
      wp[i*IW +: IW] = winport[i];
    end
    if (inpvalid) begin
      if (beats == 0) first_beat = samp;
      last_beat = samp;
      beats++;
      check("inpvalid_expected", 256'(feed_q.size() != 0), 256'(1));
      if (feed_q.size() != 0) begin
        f = feed_q.pop_front();
        check("a_raddr", 256'(ah2), 256'(f.aa));
        check("w_raddr", 256'(wh2), 256'(f.wa));
        check("ainport", 256'(ap), 256'(f.av));
        check("winport", 256'(wp), 256'(f.wv));
      end
    end
    ah2 = ah1; ah1 = a_raddr;
    wh2 = wh1; wh1 = w_raddr;
    if (r_we) begin
      n_we++;
      check("we_after_feed", 256'(beats), 256'(cur_k));
      check("outread_with_we", 256'(outread), 256'(1));
      check("r_we_expected", 256'(res_q.size() != 0), 256'(1));
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        check("r_waddr", 256'(r_waddr), 256'(r.addr));
        check("r_wdata", 256'(r_wdata), 256'(r.data));
      end
    end
    if (outread) begin
      n_or++;
      core_consumed = 1;
      check("outread_single", 256'(prev_or), 256'(0));
    end
    prev_or = outread;
    if (done) n_done++;
    if (err)  n_err++;
    if (done || err) check("done_err_excl", 256'(done && err), 256'(0));
  endtask

  task automatic issue(input vec_t v);
    feed_exp_t f;
    reset_mon();
    cur_k = int'(v.k);
    check("cmd_ready_idle", 256'(cmd_ready), 256'(1));
    if (!v.bad) begin
      for (int n = 0; n < int'(v.k); n++) begin
        f.aa = v.ab + AW'(n);
        f.wa = v.wb + AW'(n);
        f.av = amem[f.aa];
        f.wv = wmem[f.wa];
        feed_q.push_back(f);
      end
    end
    cmd_k = v.k; cmd_abase = v.ab; cmd_wbase = v.wb; cmd_rbase = v.rb;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_tile(input vec_t v);
    int cyc;
    core_rb = v.rb;
    if (!v.bad) begin
      core_left = ROWS;
      core_idx  = 0;
    end
    issue(v);
    if (!v.bad) begin
      core_left = ROWS; // issue() cleared the monitor; the core starts raising during FEED
      core_idx  = 0;
    end
    if (v.bad) begin
      check("err_bad_k", 256'(err), 256'(1));
      check("ready_after_bad", 256'(cmd_ready), 256'(1));
      for (int i = 0; i < 4; i++) step();
      check("no_inpvalid_bad", 256'(beats), 256'(0));
      check("single_err", 256'(n_err), 256'(1));
      check("no_done_bad", 256'(n_done), 256'(0));
    end else begin
      cyc = 0;
      while (n_done == 0 && n_err == 0 && cyc < 400) begin
        step();
        cyc++;
      end
      check("tile_done", 256'(n_done), 256'(1));
      check("tile_no_err", 256'(n_err), 256'(0));
      check("ready_at_done", 256'(cmd_ready), 256'(1));
      check("beat_count", 256'(beats), 256'(v.k));
      check("beats_contiguous", 256'(last_beat - first_beat + 1), 256'(v.k));
      check("write_count", 256'(n_we), 256'(ROWS));
      check("outread_count", 256'(n_or), 256'(ROWS));
      check("feed_q_empty", 256'(feed_q.size()), 256'(0));
      check("res_q_empty", 256'(res_q.size()), 256'(0));
      step();
      check("done_pulse_once", 256'(n_done), 256'(1));
    end
  endtask

  vec_t tbl[6];

  initial begin
    int cyc;
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      amem[i] = {$urandom, $urandom};
      wmem[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < ROWS; i++) routport[i] = '0;
    tbl[0] = '{k: 5'd4,  ab: 8'h10, wb: 8'h20, rb: 8'h40, bad: 1'b0};
    tbl[1] = '{k: 5'd0,  ab: 8'h00, wb: 8'h00, rb: 8'h00, bad: 1'b1};
    tbl[2] = '{k: 5'd17, ab: 8'h10, wb: 8'h20, rb: 8'h40, bad: 1'b1};
    tbl[3] = '{k: 5'd4,  ab: 8'hFE, wb: 8'h03, rb: 8'hFC, bad: 1'b0};
    tbl[4] = '{k: 5'd16, ab: 8'h80, wb: 8'hC0, rb: 8'h00, bad: 1'b0};
    tbl[5] = '{k: 5'd1,  ab: 8'h33, wb: 8'h44, rb: 8'h10, bad: 1'b0};

    reset_mon();
    cur_k = 0;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_inpvalid", 256'(inpvalid), 256'(0));
    check("rst_r_we", 256'(r_we), 256'(0));
    check("rst_outread", 256'(outread), 256'(0));
    check("rst_a_raddr", 256'(a_raddr), 256'(0));
    rstn = 1'b1;
    step();
    check("post_rst_no_done", 256'(done), 256'(0));
    check("post_rst_no_err", 256'(err), 256'(0));

    for (int t = 0; t < 6; t++) run_tile(tbl[t]);

    // Partial valid never drains; the watchdog fires.
    v = '{k: 5'd2, ab: 8'h50, wb: 8'h60, rb: 8'h70, bad: 1'b0};
    issue(v);
    for (int i = 0; i < ROWS; i++) routport[i] = $urandom;
    rvalidport = 8'hFE;
    cyc = 1;
    while (n_err == 0 && cyc < TO + 100) begin
      step();
      cyc++;
    end
    check("timeout_err", 256'(n_err), 256'(1));
    check("timeout_latency_ok", 256'(cyc >= TO && cyc <= TO + 8), 256'(1));
    check("timeout_no_we", 256'(n_we), 256'(0));
    check("timeout_no_outread", 256'(n_or), 256'(0));
    check("timeout_no_done", 256'(n_done), 256'(0));
    check("timeout_ready", 256'(cmd_ready), 256'(1));
    rvalidport = '0;
    step();

    // Reset during DRAIN after three writes aborts silently.
    v = '{k: 5'd3, ab: 8'h08, wb: 8'h09, rb: 8'h80, bad: 1'b0};
    core_rb = v.rb;
    issue(v);
    core_left = ROWS;
    core_idx  = 0;
    cyc = 0;
    while (n_we < 3 && cyc < 100) begin
      step();
      cyc++;
    end
    check("abort_three_writes", 256'(n_we), 256'(3));
    step();
    rstn = 1'b0;
    step();
    check("abort_cmd_ready", 256'(cmd_ready), 256'(1));
    check("abort_done", 256'(done), 256'(0));
    check("abort_err", 256'(err), 256'(0));
    check("abort_inpvalid", 256'(inpvalid), 256'(0));
    check("abort_r_we", 256'(r_we), 256'(0));
    check("abort_outread", 256'(outread), 256'(0));
    check("abort_r_waddr", 256'(r_waddr), 256'(0));
    rvalidport = '0;
    core_left = 0;
    core_consumed = 0;
    res_q.delete();
    feed_q.delete();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("abort_no_done", 256'(n_done), 256'(0));
    check("abort_no_more_writes", 256'(n_we), 256'(3));
    run_tile(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
